// File: rtl/uart_tx_word_fifo.sv
// Transmit word queue ahead of uart_data_tx: circular FIFO drained one word per send_en / Tx_Done handshake.
// Optional `define UART_TXQ_FLUSH_EN adds a flush input that discards queued words.
module uart_tx_word_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 3,
  parameter int GAP_CYCLES = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
`ifdef UART_TXQ_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  send_en,
  input  logic                  Tx_Done,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  overflow_q;
  logic                  flush_w;
  logic                  push, pop;

`ifdef UART_TXQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = wr_en && !full && !flush_w;
  assign pop   = (state_q == S_IDLE) && !empty;

  always_comb begin
    count_d = count_q;
    if (flush_w)
      count_d = '0;
    else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: if (pop) state_d = S_LOAD;
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (Tx_Done) begin
          if (GAP_CYCLES == 0)
            state_d = S_IDLE;
          else begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage is not reset: contents are only visible through the pointers.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      gap_q      <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      overflow_q <= wr_en && full && !flush_w;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (flush_w)  rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (pop) data_q <= mem_q[rd_ptr_q];
    end
  end

  assign level    = count_q;
  assign overflow = overflow_q;
  assign data     = data_q;
  assign send_en  = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_word_fifo.sv
// Randomized bench for uart_tx_word_fifo against a queue-based transaction model.
// Build with UART_TXQ_FLUSH_EN defined to also exercise the flush port.
module tb_uart_tx_word_fifo;
  localparam int DW = 32;
  localparam int DL = 3;
  localparam int G = 16;
  localparam int DEPTH = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          Tx_Done = 1'b0;
  logic          fl_drv = 1'b0;
  logic          full, empty, overflow, send_en, busy;
  logic [DL:0]   level;
  logic [DW-1:0] data;

  uart_tx_word_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .GAP_CYCLES(G)) dut (
    .Clk(Clk), .Rst(Rst), .wr_data(wr_data), .wr_en(wr_en),
`ifdef UART_TXQ_FLUSH_EN
    .flush(fl_drv),
`endif
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .data(data), .send_en(send_en), .Tx_Done(Tx_Done), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Transaction model: a queue of pending words plus the handshake phase of the word in flight.
  logic [31:0] mq[$];
  logic [31:0] sent_q[$];
  bit          m_loaded, m_waiting, m_ovf;
  int          m_gap;
  logic [31:0] m_data;
  int          n_send_seen, n_push_model, ovf_seen, peak_level;

  task automatic step(input bit we, input logic [31:0] wd, input bit td, input bit rs);
    int sz;
    wr_en = we; wr_data = wd; Tx_Done = td; Rst = rs;
    @(posedge Clk);
    sz = mq.size();
    if (rs) begin
      mq.delete(); m_loaded = 0; m_waiting = 0; m_gap = 0; m_data = '0; m_ovf = 0;
    end else begin
      m_ovf = we && (sz == DEPTH) && !fl_drv;
      if (m_loaded) begin
        m_loaded = 0; m_waiting = 1;
      end else if (m_waiting) begin
        if (td) begin m_waiting = 0; m_gap = G; end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (sz > 0) begin
        m_data = mq.pop_front(); m_loaded = 1;
      end
      if (fl_drv) mq.delete();
      else if (we && sz < DEPTH) begin mq.push_back(wd); n_push_model++; end
    end
    @(negedge Clk);
    check("send_en", {31'd0, send_en}, {31'd0, m_loaded});
    check("busy", {31'd0, busy}, {31'd0, (m_loaded || m_waiting || m_gap > 0)});
    check("level", 32'(level), 32'(mq.size()));
    check("full", {31'd0, full}, {31'd0, (mq.size() == DEPTH)});
    check("empty", {31'd0, empty}, {31'd0, (mq.size() == 0)});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("data", data, m_data);
    if (send_en) begin n_send_seen++; sent_q.push_back(data); end
    if (overflow) ovf_seen++;
    if (int'(level) > peak_level) peak_level = int'(level);
    wr_en = 0; Tx_Done = 0; Rst = 0; fl_drv = 0;
  endtask

  task automatic wait_send(output int n);
    n = 0;
    do begin step(0, '0, 0, 0); n++; end while (!send_en && n < 200);
    if (!send_en) check("wait_send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while ((mq.size() > 0 || m_loaded || m_waiting || m_gap > 0) && k < 5000) begin
      step(0, '0, ($urandom_range(0, 5) == 0), 0);
      k++;
    end
    check("drain_timeout", {31'd0, (k < 5000)}, 32'd1);
  endtask

  initial begin
    int n, i, s0, p0;
    logic [31:0] burst [3];
    burst[0] = 32'h12345678; burst[1] = 32'h87654321; burst[2] = 32'h24680135;

    step(0, '0, 0, 1);
    step(0, '0, 0, 1);

    // Single word, then a late Tx_Done opens a gap of G busy cycles.
    step(1, 32'h12345678, 0, 0);
    wait_send(n);
    check("single_latency", n, 1);
    check("single_data", data, 32'h12345678);
    check("single_level", 32'(level), 0);
    repeat (500) step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    n = 0;
    while (busy && n < 100) begin step(0, '0, 0, 0); n++; end
    check("gap_busy_cycles", n, G);

    // Burst of three; next send_en lands G+1 clocks after the edge that samples Tx_Done.
    peak_level = 0;
    for (int k = 0; k < 3; k++) step(1, burst[k], 0, 0);
    check("burst_peak_level", peak_level, 2);
    for (int k = 0; k < 2; k++) begin
      repeat (7) step(0, '0, 0, 0);
      step(0, '0, 1, 0);
      wait_send(n);
      check("burst_spacing", n, G + 1);
      check("burst_order", data, burst[k + 1]);
    end
    repeat (5) step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    drain();

    // Overflow: ten back-to-back writes with the UART stalled.
    sent_q.delete(); ovf_seen = 0;
    for (int k = 0; k < 10; k++) step(1, 32'(k), 0, 0);
    check("ovf_full", {31'd0, full}, 32'd1);
    step(0, '0, 0, 0);
    check("ovf_pulses", ovf_seen, 1);
    drain();
    check("ovf_sent_count", sent_q.size(), 9);
    for (int k = 0; k < 9 && k < sent_q.size(); k++) check("ovf_order", sent_q[k], 32'(k));

    // Wrap-around with level held at or below four.
    sent_q.delete(); ovf_seen = 0; i = 0; n = 0;
    while (i < 20 && n < 20000) begin
      if (mq.size() < 4 && $urandom_range(0, 1) == 1) begin
        step(1, 32'hC000_0000 + 32'(i), ($urandom_range(0, 3) == 0), 0);
        i++;
      end else step(0, '0, ($urandom_range(0, 3) == 0), 0);
      n++;
    end
    drain();
    check("wrap_sent_count", sent_q.size(), 20);
    for (int k = 0; k < 20 && k < sent_q.size(); k++) check("wrap_order", sent_q[k], 32'hC000_0000 + 32'(k));
    check("wrap_no_overflow", ovf_seen, 0);

    // Random traffic including stray Tx_Done pulses in every phase.
    s0 = n_send_seen; p0 = n_push_model;
    repeat (3000) step(($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 3) == 0), 0);
    drain();
    check("random_send_count", n_send_seen - s0, n_push_model - p0);

    // Reset while a word is in WAIT and three more are queued.
    for (int k = 0; k < 4; k++) step(1, 32'hB0 + 32'(k), 0, 0);
    step(0, '0, 0, 0);
    check("rst_pre_level", 32'(level), 3);
    step(0, '0, 0, 1);
    check("rst_level", 32'(level), 0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_send_en", {31'd0, send_en}, 32'd0);
    step(1, 32'hA5A5A5A5, 0, 0);
    wait_send(n);
    check("post_rst_latency", n, 1);
    check("post_rst_data", data, 32'hA5A5A5A5);
    step(0, '0, 1, 0);
    drain();

`ifdef UART_TXQ_FLUSH_EN
    step(1, 32'hF00D0000, 0, 0);
    wait_send(n);
    for (int k = 1; k <= 5; k++) step(1, 32'hF00D0000 + 32'(k), 0, 0);
    check("flush_pre_level", 32'(level), 5);
    fl_drv = 1;
    step(0, '0, 0, 0);
    check("flush_level", 32'(level), 0);
    check("flush_busy_kept", {31'd0, busy}, 32'd1);
    s0 = n_send_seen;
    step(0, '0, 1, 0);
    repeat (60) step(0, '0, 0, 0);
    check("flush_no_send", n_send_seen - s0, 0);
    check("flush_idle", {31'd0, busy}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
